mem_access_ctrl: RTL and testbench

Sequencer and arbiter for the processor's single-port unified memory, sitting between the fetch stage, the MEM stage (fed by the EX/MEM pipeline register's `mem_addr_M` / `mem_wd_M` / `rd_en_M` / `wr_en_dmem_M` outputs) and the memory macro. It grants one requester at a time and runs a fixed wait-state access cycle. It returns read data with a one-cycle ready pulse and drives the stall signals that freeze the fetch stage and the EX/MEM register while an access is outstanding. It also keeps a saturating count of fetch cycles lost to data accesses.

---
 rtl/mem_ctrl_pkg.sv | 9 +
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified-memory access controller.
// Owner encoding is fixed (fetch=0, MEM stage=1) so it can be observed on a bus.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;

    localparam int WAIT_CYCLES_DEF = 1;
    localparam int CNT_W           = 3;
endpackage

// File: rtl/mem_access_ctrl.sv
// Single-port memory sequencer: arbitrates fetch vs. MEM stage (MEM wins), runs a
// fixed wait-state access, returns data with a one-cycle ready and drives the stalls.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              m_rd_en,
    input  logic              m_wr_en,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [7:0]        fetch_lost
);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               re_q, re_d, we_q, we_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d, m_rdata_q, m_rdata_d;
    logic [7:0]         fetch_lost_q, fetch_lost_d;
    logic               m_req, fl_inc;

    assign m_req = m_rd_en | m_wr_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m_req || if_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0)     state_d = DONE;
            DONE:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        if_ready  = (state_q == DONE) && (owner_q == OWN_IF);
        m_ready   = (state_q == DONE) && (owner_q == OWN_MEM);
        stall_if  = if_req & ~if_ready;
        stall_mem = m_req & ~m_ready;
    end

    // Grant latches the whole request; a simultaneous read+write is a store.
    always_comb begin
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        re_d       = re_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        m_rdata_d  = m_rdata_q;
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    owner_d = OWN_MEM;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    we_d    = m_wr_en;
                    re_d    = ~m_wr_en;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end else if (if_req) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    re_d    = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    re_d = 1'b0;
                    we_d = 1'b0;
                    if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
                    else if (re_q)         m_rdata_d  = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Fetch is counted as lost on the MEM grant and each MEM ACCESS cycle, not in DONE.
    assign fl_inc = if_req & (((state_q == IDLE) & m_req) |
                              ((state_q == ACCESS) & (owner_q == OWN_MEM)));
    assign fetch_lost_d = (fl_inc && fetch_lost_q != 8'hFF) ? fetch_lost_q + 8'd1
                                                            : fetch_lost_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_IF;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            if_rdata_q   <= '0;
            m_rdata_q    <= '0;
            fetch_lost_q <= '0;
        end else begin
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            re_q         <= re_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            m_rdata_q    <= m_rdata_d;
            fetch_lost_q <= fetch_lost_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_re     = re_q;
    assign mem_we     = we_q;
    assign if_rdata   = if_rdata_q;
    assign m_rdata    = m_rdata_q;
    assign fetch_lost = fetch_lost_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of single transactions, a contended fetch/load
// sequence, reset abort mid-access and fetch_lost saturation, with a ready scoreboard.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_req, m_rd_en, m_wr_en;
    logic [7:0] if_addr, m_addr, m_wdata;
    logic [7:0] if_rdata, m_rdata, mem_addr, mem_wdata, mem_rdata, fetch_lost;
    logic       if_ready, m_ready, mem_re, mem_we, stall_if, stall_mem;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
        .fetch_lost(fetch_lost)
    );

    always #5 clk = ~clk;

    // Memory: unwritten locations read as addr ^ 0xB5 (so 0x10 -> 0xA5).
    bit [7:0] wmem [256];
    bit       wflag[256];
    assign mem_rdata = wflag[mem_addr] ? wmem[mem_addr] : (mem_addr ^ 8'hB5);
    always @(posedge clk) if (mem_we) begin
        wmem[mem_addr]  <= mem_wdata;
        wflag[mem_addr] <= 1'b1;
    end

    int n_cmp = 0, n_bad = 0, done_cnt = 0;
    bit sb_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { bit own; logic [7:0] data; } sb_t;
    sb_t sbq[$];

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (if_ready || m_ready) begin
            done_cnt++;
            if (sb_en) begin
                if (sbq.size() == 0) chk("unexpected_ready", 1, 0);
                else begin
                    e = sbq.pop_front();
                    if (e.own) begin
                        chk("m_ready_owner", {m_ready, if_ready}, 2'b10);
                        chk("m_rdata", m_rdata, e.data);
                    end else begin
                        chk("if_ready_owner", {m_ready, if_ready}, 2'b01);
                        chk("if_rdata", if_rdata, e.data);
                    end
                end
            end
        end
    end

    typedef struct {
        bit is_mem; bit rd; bit wr; logic [7:0] addr; logic [7:0] wdata;
        logic [7:0] exp_data; bit exp_we;
    } vec_t;

    task automatic idle_inputs();
        if_req = 0; m_rd_en = 0; m_wr_en = 0;
    endtask

    task automatic do_txn(input vec_t v);
        int n, acc;
        bit seen;
        @(negedge clk);
        if_req = !v.is_mem; if_addr = v.addr;
        m_rd_en = v.rd; m_wr_en = v.wr; m_addr = v.addr; m_wdata = v.wdata;
        sbq.push_back('{own: v.is_mem, data: v.exp_data});
        n = 0; acc = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1; n++;
            if (mem_re | mem_we) acc++;
            if (n == 1) begin
                chk("mem_addr", mem_addr, v.addr);
                chk("mem_we", mem_we, v.exp_we);
                chk("mem_re", mem_re, !v.exp_we);
                if (v.exp_we) chk("mem_wdata", mem_wdata, v.wdata);
            end
            if (if_ready | m_ready) seen = 1;
        end
        chk("ready_seen", seen, 1);
        chk("latency", n, 3);
        chk("access_cycles", acc, 2);
        chk("stall_at_ready", stall_if | stall_mem, 0);
        idle_inputs();
        @(posedge clk); #1;
        chk("ready_one_pulse", if_ready | m_ready, 0);
    endtask

    vec_t vecs[10];

    initial begin
        int n, mn, fl0, rdy;
        vecs[0] = '{0, 0, 0, 8'h10, 8'h00, 8'hA5, 0};  // fetch, preset data
        vecs[1] = '{1, 0, 1, 8'h20, 8'h3C, 8'h00, 1};  // store, m_rdata stays 0
        vecs[2] = '{1, 1, 0, 8'h20, 8'h00, 8'h3C, 0};  // load back
        vecs[3] = '{1, 1, 1, 8'h30, 8'h77, 8'h3C, 1};  // rd+wr = store
        vecs[4] = '{1, 1, 0, 8'h30, 8'h00, 8'h77, 0};
        vecs[5] = '{0, 0, 0, 8'h30, 8'h00, 8'h77, 0};  // fetch sees store
        vecs[6] = '{0, 0, 0, 8'hFF, 8'h00, 8'h4A, 0};
        vecs[7] = '{1, 1, 0, 8'h00, 8'h00, 8'hB5, 0};
        vecs[8] = '{1, 0, 1, 8'hFF, 8'h00, 8'hB5, 1};
        vecs[9] = '{0, 0, 0, 8'hFF, 8'h00, 8'h00, 0};

        reset = 0; if_req = 1; m_rd_en = 0; m_wr_en = 0;
        if_addr = 0; m_addr = 0; m_wdata = 0;
        #12;
        chk("rst_stall_if", stall_if, 1);
        chk("rst_stall_mem", stall_mem, 0);
        chk("rst_outputs", {if_rdata, m_rdata, mem_addr, mem_wdata, fetch_lost,
                            if_ready, m_ready, mem_re, mem_we}, 0);
        if_req = 0;
        @(negedge clk); reset = 1;

        foreach (vecs[i]) do_txn(vecs[i]);

        // Contended: MEM load first, fetch afterwards.
        fl0 = fetch_lost;
        @(negedge clk);
        if_req = 1; if_addr = 8'h10; m_rd_en = 1; m_addr = 8'h20;
        sbq.push_back('{own: 1, data: 8'h3C});
        sbq.push_back('{own: 0, data: 8'hA5});
        n = 0; mn = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (m_ready) begin
                mn = n;
                chk("stall_if_during_mem", stall_if, 1);
                m_rd_en = 0;
            end
            if (if_ready) break;
        end
        chk("contend_m_latency", mn, 3);
        chk("contend_if_latency", n, 7);
        chk("contend_fetch_lost", fetch_lost - fl0, 3);
        idle_inputs();
        repeat (2) @(posedge clk);

        // Reset mid-access: store aborted, no ready afterwards.
        @(negedge clk);
        m_wr_en = 1; m_addr = 8'h40; m_wdata = 8'h99;
        @(posedge clk); @(posedge clk); #3;
        reset = 0; #1;
        chk("abort_outputs", {if_rdata, m_rdata, mem_addr, mem_wdata, fetch_lost,
                              if_ready, m_ready, mem_re, mem_we}, 0);
        @(negedge clk); m_wr_en = 0; reset = 1;
        rdy = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (if_ready | m_ready | mem_re | mem_we) rdy++;
        end
        chk("abort_no_activity", rdy, 0);

        // Saturation: continuous contention.
        sb_en = 0;
        @(negedge clk);
        if_req = 1; if_addr = 8'h10; m_rd_en = 1; m_addr = 8'h20;
        repeat (400) @(posedge clk);
        #1 chk("fetch_lost_sat", fetch_lost, 255);
        @(negedge clk); idle_inputs();
        repeat (5) @(posedge clk);
        #1 chk("fetch_lost_hold", fetch_lost, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
